// File: rtl/cbus_sram_responder_pkg.sv
// Shared cbus transaction types, burst encodings and responder FSM states.
package cbus_sram_responder_pkg;

    typedef logic [3:0] mlen_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

endpackage

// File: rtl/cbus_sram_responder_sram_1rw.sv
// Single-port word SRAM: registered read, per-byte write enables, no reset.
module sram_1rw #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cbus_sram_responder.sv
// cbus target backed by on-chip SRAM; serves single and INCR/FIXED bursts
// with a fixed request-to-first-beat latency.
module cbus_sram_responder
    import cbus_sram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WW = $clog2(LATENCY + 1);

    state_t         state;
    state_t         state_nx;
    logic [WW-1:0]  wait_cnt;
    mlen_t          beat;
    mlen_t          len_q;
    logic           is_write_q;
    logic [1:0]     burst_q;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  idx_inc;
    logic [AW-1:0]  sram_addr;
    logic           sram_we;
    logic [31:0]    sram_rdata;
    logic           beat_ok;
    logic           unused_req_bits;

    assign unused_req_bits = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};

    // Index of the following beat; FIXED bursts stay on one word, others wrap.
    assign idx_inc = (burst_q == AXI_BURST_FIXED) ? idx : idx + AW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The SRAM address always points at the word needed next cycle, so the
    // registered read lands exactly on the ready beat.
    always_comb begin
        state_nx  = state;
        beat_ok   = 1'b0;
        sram_addr = idx;
        sram_we   = 1'b0;
        cresp     = '0;
        unique case (state)
            IDLE: begin
                sram_addr = creq.addr[2 +: AW];
                if (creq.valid) begin
                    state_nx = (LATENCY == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    state_nx = IDLE;
                end else if (wait_cnt == '0) begin
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    state_nx = IDLE;
                end else begin
                    beat_ok     = 1'b1;
                    cresp.ready = 1'b1;
                    cresp.last  = (beat == len_q);
                    cresp.data  = is_write_q ? 32'h0 : sram_rdata;
                    if (is_write_q) begin
                        sram_we = 1'b1;
                    end else begin
                        sram_addr = idx_inc;
                    end
                    if (beat == len_q) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt   <= '0;
            beat       <= '0;
            len_q      <= '0;
            is_write_q <= 1'b0;
            burst_q    <= '0;
            idx        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (creq.valid) begin
                        idx        <= creq.addr[2 +: AW];
                        len_q      <= creq.len;
                        is_write_q <= creq.is_write;
                        burst_q    <= creq.burst;
                        beat       <= '0;
                        wait_cnt   <= WW'(LATENCY - 2);
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                BURST: begin
                    if (beat_ok) begin
                        beat <= beat + 4'd1;
                        idx  <= idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    sram_1rw #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .be    (creq.strobe),
        .addr  (sram_addr),
        .wdata (creq.data),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder: a LATENCY=2 and a LATENCY=1 instance.
module tb_cbus_sram_responder;
    import cbus_sram_responder_pkg::*;

    logic       clk;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    cbus_req_t  creq1;
    cbus_resp_t cresp1;
    int         sel;
    int         n_cmp;
    int         n_fail;

    cbus_sram_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .clk(clk), .resetn(resetn), .creq(creq), .cresp(cresp)
    );

    cbus_sram_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .creq(creq1), .cresp(cresp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input cbus_req_t r);
        if (sel != 0) creq1 = r;
        else          creq  = r;
    endtask

    function automatic cbus_resp_t rsp();
        return (sel != 0) ? cresp1 : cresp;
    endfunction

    function automatic cbus_req_t mk(input logic wr, input int unsigned idx, input logic [31:0] d,
                                     input logic [3:0] strb, input mlen_t len, input logic [1:0] burst);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd2;
        r.addr     = idx << 2;
        r.strobe   = strb;
        r.data     = d;
        r.len      = len;
        r.burst    = burst;
        return r;
    endfunction

    task automatic write_word(input int unsigned idx, input logic [31:0] d);
        cbus_resp_t r;
        drive(mk(1'b1, idx, d, 4'hF, 4'd0, AXI_BURST_INCR));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            r = rsp();
            if (r.ready) break;
            tick();
        end
        tick();
        drive('0);
    endtask

    task automatic read_word(input int unsigned idx, output logic [31:0] d);
        cbus_resp_t r;
        d = 'x;
        drive(mk(1'b0, idx, 32'h0, 4'h0, 4'd0, AXI_BURST_INCR));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            r = rsp();
            if (r.ready) begin
                d = r.data;
                break;
            end
            tick();
        end
        tick();
        drive('0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        sel = 0;
        n_cmp++;
        if (cresp !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: cresp=%h expected 0", cresp);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        write_word(5, 32'hCAFEF00D);
        drive(mk(1'b0, 5, 32'h0, 4'h0, 4'd3, AXI_BURST_INCR));
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if (cresp.ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_preburst_ready: ready=%b expected 1", cresp.ready);
        end
        #1 resetn = 1'b0;
        #1;
        n_cmp++;
        if (cresp !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_midburst_drop: cresp=%h expected 0", cresp);
        end
        drive('0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if (cresp !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_after_release_idle: cresp=%h expected 0", cresp);
        end
        tick();
        read_word(5, d);
        n_cmp++;
        if (d !== 32'hCAFEF00D) begin
            n_fail++;
            $display("[TB] FAIL reset_sram_intact: data=%h expected cafef00d", d);
        end
    endtask

    task automatic test_single_write_read();
        sel = 0;
        write_word(4, 32'h11223344);
        drive(mk(1'b1, 4, 32'hDEADBEEF, 4'b0101, 4'd0, AXI_BURST_INCR));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (cresp.ready !== (c == 2) || cresp.last !== (c == 2) || cresp.data !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL single_write_c%0d: ready=%b last=%b data=%h expected %b %b 0",
                         c, cresp.ready, cresp.last, cresp.data, c == 2, c == 2);
            end
            tick();
        end
        drive('0);
        drive(mk(1'b0, 4, 32'h0, 4'h0, 4'd0, AXI_BURST_INCR));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (cresp.ready !== (c == 2) || cresp.last !== (c == 2)
                || cresp.data !== ((c == 2) ? 32'h11AD33EF : 32'h0)) begin
                n_fail++;
                $display("[TB] FAIL single_read_c%0d: ready=%b last=%b data=%h expected %b %b %h",
                         c, cresp.ready, cresp.last, cresp.data, c == 2, c == 2,
                         (c == 2) ? 32'h11AD33EF : 32'h0);
            end
            tick();
        end
        drive('0);
        tick();
    endtask

    task automatic test_incr_read();
        logic [31:0] exp_d;
        sel = 0;
        for (int i = 0; i < 4; i++) write_word(4 + i, 32'hA0 + 32'(i));
        drive(mk(1'b0, 4, 32'h0, 4'h0, 4'd3, AXI_BURST_INCR));
        for (int c = 0; c < 7; c++) begin
            exp_d = (c >= 2 && c <= 5) ? 32'hA0 + 32'(c - 2) : 32'h0;
            @(negedge clk);
            n_cmp++;
            if (cresp.ready !== (c >= 2 && c <= 5) || cresp.last !== (c == 5) || cresp.data !== exp_d) begin
                n_fail++;
                $display("[TB] FAIL incr_read_c%0d: ready=%b last=%b data=%h expected %b %b %h",
                         c, cresp.ready, cresp.last, cresp.data, c >= 2 && c <= 5, c == 5, exp_d);
            end
            tick();
        end
        drive('0);
        tick();
        tick();
    endtask

    task automatic test_wrap_fixed();
        cbus_req_t   r;
        logic [31:0] d;
        logic [31:0] exp_d;
        sel = 0;
        write_word(63, 32'h63636363);
        write_word(0, 32'h00000B0B);
        write_word(9, 32'h99999999);
        write_word(10, 32'h55555555);
        r = mk(1'b0, 63, 32'h0, 4'h0, 4'd1, AXI_BURST_INCR);
        r.addr = r.addr | 32'h8000_0000;
        drive(r);
        for (int c = 0; c < 4; c++) begin
            exp_d = (c == 2) ? 32'h63636363 : (c == 3) ? 32'h00000B0B : 32'h0;
            @(negedge clk);
            n_cmp++;
            if (cresp.ready !== (c >= 2) || cresp.last !== (c == 3) || cresp.data !== exp_d) begin
                n_fail++;
                $display("[TB] FAIL wrap_read_c%0d: ready=%b last=%b data=%h expected %b %b %h",
                         c, cresp.ready, cresp.last, cresp.data, c >= 2, c == 3, exp_d);
            end
            tick();
        end
        drive('0);
        for (int c = 0; c < 5; c++) begin
            d = (c <= 2) ? 32'h11110000 : (c == 3) ? 32'h22220000 : 32'h33330000;
            drive(mk(1'b1, 9, d, 4'hF, 4'd2, AXI_BURST_FIXED));
            @(negedge clk);
            n_cmp++;
            if (cresp.ready !== (c >= 2) || cresp.last !== (c == 4)) begin
                n_fail++;
                $display("[TB] FAIL fixed_write_c%0d: ready=%b last=%b expected %b %b",
                         c, cresp.ready, cresp.last, c >= 2, c == 4);
            end
            tick();
        end
        drive('0);
        read_word(9, d);
        n_cmp++;
        if (d !== 32'h33330000) begin
            n_fail++;
            $display("[TB] FAIL fixed_final_word: data=%h expected 33330000", d);
        end
        read_word(10, d);
        n_cmp++;
        if (d !== 32'h55555555) begin
            n_fail++;
            $display("[TB] FAIL fixed_neighbour: data=%h expected 55555555", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ready_mask;
        logic [7:0]  last_mask;
        logic [31:0] exp_d;
        sel = 0;
        ready_mask = 8'b1100_1100;
        last_mask  = 8'b1000_1000;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(mk(1'b0, 4, 32'h0, 4'h0, 4'd1, AXI_BURST_INCR));
            if (c == 4) drive(mk(1'b0, 6, 32'h0, 4'h0, 4'd1, AXI_BURST_INCR));
            case (c)
                2:       exp_d = 32'hA0;
                3:       exp_d = 32'hA1;
                6:       exp_d = 32'hA2;
                7:       exp_d = 32'hA3;
                default: exp_d = 32'h0;
            endcase
            @(negedge clk);
            n_cmp++;
            if (cresp.ready !== ready_mask[c] || cresp.last !== last_mask[c] || cresp.data !== exp_d) begin
                n_fail++;
                $display("[TB] FAIL b2b_c%0d: ready=%b last=%b data=%h expected %b %b %h",
                         c, cresp.ready, cresp.last, cresp.data, ready_mask[c], last_mask[c], exp_d);
            end
            tick();
        end
        drive('0);
        tick();
    endtask

    task automatic test_latency1_drop();
        logic [31:0] d;
        sel = 1;
        for (int i = 20; i < 24; i++) write_word(i, 32'h2000 + 32'(i));
        drive(mk(1'b1, 20, 32'hB0, 4'hF, 4'd3, AXI_BURST_INCR));
        for (int c = 0; c < 6; c++) begin
            if (c == 2) drive(mk(1'b1, 20, 32'hB1, 4'hF, 4'd3, AXI_BURST_INCR));
            if (c == 3) drive('0);
            if (c == 4) drive(mk(1'b0, 22, 32'h0, 4'h0, 4'd0, AXI_BURST_INCR));
            @(negedge clk);
            n_cmp++;
            if (cresp1.ready !== (c == 1 || c == 2 || c == 5) || cresp1.last !== (c == 5)
                || cresp1.data !== ((c == 5) ? 32'h2016 : 32'h0)) begin
                n_fail++;
                $display("[TB] FAIL lat1_c%0d: ready=%b last=%b data=%h expected %b %b %h",
                         c, cresp1.ready, cresp1.last, cresp1.data, c == 1 || c == 2 || c == 5,
                         c == 5, (c == 5) ? 32'h2016 : 32'h0);
            end
            tick();
        end
        drive('0);
        read_word(20, d);
        n_cmp++;
        if (d !== 32'hB0) begin
            n_fail++;
            $display("[TB] FAIL lat1_beat0_word: data=%h expected b0", d);
        end
        read_word(21, d);
        n_cmp++;
        if (d !== 32'hB1) begin
            n_fail++;
            $display("[TB] FAIL lat1_beat1_word: data=%h expected b1", d);
        end
        read_word(23, d);
        n_cmp++;
        if (d !== 32'h2017) begin
            n_fail++;
            $display("[TB] FAIL lat1_untouched_word: data=%h expected 2017", d);
        end
        sel = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        sel    = 0;
        resetn = 1'b0;
        creq   = '0;
        creq1  = '0;
        #2;
        test_reset();
        test_single_write_read();
        test_incr_read();
        test_wrap_fixed();
        test_back_to_back();
        test_latency1_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
